// File: rtl/tdc_result_fifo_spi_if.sv
// Signal bundle between the TDC core / SPI host side and the result FIFO.
// The master modport is the environment side; the slave modport is the FIFO block.
interface tdc_result_fifo_spi_if #(
  parameter int DEPTH    = 4,
  parameter int COARSE_W = 32,
  parameter int FINE_W   = 9
);
  logic                    tdc_busy;
  logic [COARSE_W-1:0]     coarse_result;
  logic [FINE_W-1:0]       fine_result;
  logic                    spi_sclk;
  logic                    spi_cs_n;
  logic                    spi_miso;
  logic                    data_ready;
  logic                    overflow;
  logic [$clog2(DEPTH):0]  fifo_count;

  modport master (
    output tdc_busy, coarse_result, fine_result, spi_sclk, spi_cs_n,
    input  spi_miso, data_ready, overflow, fifo_count
  );

  modport slave (
    input  tdc_busy, coarse_result, fine_result, spi_sclk, spi_cs_n,
    output spi_miso, data_ready, overflow, fifo_count
  );
endinterface

// File: rtl/tdc_result_fifo_spi.sv
// Captures TDC results on busy falling into a small FIFO and serves them over a read-only SPI slave (mode 0).
// Optional TDC_FIFO_SEQ_EN adds a 7-bit capture sequence number in record bits [47:41].
module tdc_result_fifo_spi #(
  parameter int DEPTH    = 4,
  parameter int COARSE_W = 32,
  parameter int FINE_W   = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  tdc_result_fifo_spi_if.slave   bus
);
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;
  localparam int DATA_W = COARSE_W + FINE_W;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  logic              r_busy_s1, r_busy_s2, r_busy_h;
  logic              r_sclk_s1, r_sclk_s2, r_sclk_h;
  logic              r_cs_s1, r_cs_s2, r_cs_h;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wp, r_rp;
  logic [CW-1:0]     r_count, w_count_nxt;
  logic              r_overflow, r_data_ready;
  state_t            r_state;
  logic [55:0]       r_frame;
  logic [5:0]        r_bit_cnt;
  logic              r_valid, r_miso;
  logic              w_push, w_wr, w_pop, w_full, w_valid;
  logic              w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;
  logic [47:0]       w_rec;
  logic [55:0]       w_frame;
`ifdef TDC_FIFO_SEQ_EN
  logic [6:0]        r_seq;
  logic [6:0]        r_mem_seq [DEPTH];
`endif

  function automatic logic [2:0] sat_count(input logic [CW-1:0] c);
    if (int'(c) > 7) return 3'd7;
    else             return 3'(c);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {r_busy_s1, r_busy_s2, r_busy_h} <= 3'b000;
      {r_sclk_s1, r_sclk_s2, r_sclk_h} <= 3'b000;
      {r_cs_s1, r_cs_s2, r_cs_h}       <= 3'b111;
    end else begin
      {r_busy_s1, r_busy_s2, r_busy_h} <= {bus.tdc_busy, r_busy_s1, r_busy_s2};
      {r_sclk_s1, r_sclk_s2, r_sclk_h} <= {bus.spi_sclk, r_sclk_s1, r_sclk_s2};
      {r_cs_s1, r_cs_s2, r_cs_h}       <= {bus.spi_cs_n, r_cs_s1, r_cs_s2};
    end
  end

  assign w_push      = r_busy_h & ~r_busy_s2;
  assign w_sclk_rise = r_sclk_s2 & ~r_sclk_h;
  assign w_sclk_fall = ~r_sclk_s2 & r_sclk_h;
  assign w_cs_fall   = r_cs_h & ~r_cs_s2;
  assign w_cs_rise   = r_cs_s2 & ~r_cs_h;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_valid = (r_count != '0);
  assign w_pop   = (r_state == S_DONE) & w_cs_rise & r_valid;
  // A full FIFO still accepts a push when the same cycle pops the head.
  assign w_wr    = w_push & (~w_full | w_pop);

  always_comb begin
    case ({w_wr, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wp] <= {bus.fine_result, bus.coarse_result};
`ifdef TDC_FIFO_SEQ_EN
      r_mem_seq[r_wp] <= r_seq;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp         <= '0;
      r_rp         <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_data_ready <= 1'b0;
    end else begin
      if (w_wr)  r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_count      <= w_count_nxt;
      r_data_ready <= (w_count_nxt != '0);
      r_overflow   <= (r_overflow & ~w_pop) | (w_push & ~w_wr);
    end
  end

`ifdef TDC_FIFO_SEQ_EN
  // Dropped captures still consume a number so the host can see the gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_seq <= 7'd0;
    else if (w_push) r_seq <= r_seq + 7'd1;
  end
`endif

  always_comb begin
    w_rec = '0;
    w_rec[DATA_W-1:0] = r_mem[r_rp];
`ifdef TDC_FIFO_SEQ_EN
    w_rec[47:41] = r_mem_seq[r_rp];
`endif
  end

  assign w_frame = {w_valid, r_overflow, 3'b000, sat_count(r_count), w_valid ? w_rec : 48'd0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_frame   <= '0;
      r_bit_cnt <= '0;
      r_valid   <= 1'b0;
      r_miso    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_miso <= 1'b0;
          if (w_cs_fall) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_frame   <= w_frame;
          r_valid   <= w_valid;
          r_bit_cnt <= 6'd0;
          if (w_cs_rise) begin
            r_miso  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_miso  <= w_frame[55];
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_cs_rise) begin
            r_miso  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_sclk_rise) begin
            r_bit_cnt <= r_bit_cnt + 6'd1;
            if (r_bit_cnt == 6'd55) begin
              r_miso  <= 1'b0;
              r_state <= S_DONE;
            end
          end else if (w_sclk_fall) begin
            r_frame <= {r_frame[54:0], 1'b0};
            r_miso  <= r_frame[54];
          end
        end
        S_DONE: begin
          r_miso <= 1'b0;
          if (w_cs_rise) r_state <= S_IDLE;
        end
        default: begin
          r_miso  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.spi_miso   = r_miso;
  assign bus.data_ready = r_data_ready;
  assign bus.overflow   = r_overflow;
  assign bus.fifo_count = r_count;
endmodule

// File: tb/tb_tdc_result_fifo_spi.sv
// Directed bench for tdc_result_fifo_spi: capture, overflow, short reads, push/pop collision, reset abort.
// Expected record sequence bits follow TDC_FIFO_SEQ_EN when the bench is built with it.
module tb_tdc_result_fifo_spi;
  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic [55:0] f;

  tdc_result_fifo_spi_if #(.DEPTH(4), .COARSE_W(32), .FINE_W(9)) bus ();

  tdc_result_fifo_spi #(.DEPTH(4), .COARSE_W(32), .FINE_W(9)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [55:0] frm(input logic v, input logic ov, input int cnt, input int seq,
                                      input logic [31:0] co, input logic [8:0] fi);
    logic [47:0] r;
    logic [6:0]  s;
    s = 7'(seq);
    r = {7'd0, fi, co};
`ifdef TDC_FIFO_SEQ_EN
    r[47:41] = s;
`endif
    if (!v) r = '0;
    return {v, ov, 3'b000, 3'(cnt), r};
  endfunction

  task automatic capture(input logic [31:0] co, input logic [8:0] fi);
    @(negedge clk);
    bus.tdc_busy = 1'b1;
    bus.coarse_result = co;
    bus.fine_result = fi;
    repeat (3) @(negedge clk);
    bus.tdc_busy = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  // Leaves cs_n low; the caller decides when the host deselects.
  task automatic spi_read(input int nbits, output logic [55:0] fr);
    fr = '0;
    bus.spi_cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      fr = {fr[54:0], bus.spi_miso};
      bus.spi_sclk = 1'b1;
      repeat (8) @(negedge clk);
      bus.spi_sclk = 1'b0;
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic read_full(output logic [55:0] fr);
    spi_read(56, fr);
    bus.spi_cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.tdc_busy = 1'b0;
    bus.coarse_result = 32'd0;
    bus.fine_result = 9'd0;
    bus.spi_sclk = 1'b0;
    bus.spi_cs_n = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_count", 64'(bus.fifo_count), 64'd0);
    chk("rst_ready", 64'(bus.data_ready), 64'd0);
    chk("rst_ovf", 64'(bus.overflow), 64'd0);
    chk("rst_miso", 64'(bus.spi_miso), 64'd0);

    read_full(f);
    chk("empty_frame", 64'(f), 64'd0);
    chk("empty_miso", 64'(bus.spi_miso), 64'd0);
    chk("empty_count", 64'(bus.fifo_count), 64'd0);

    // Single capture with data_ready latency measured against clk edges.
    @(negedge clk);
    bus.tdc_busy = 1'b1;
    bus.coarse_result = 32'h0000_0005;
    bus.fine_result = 9'h07A;
    repeat (3) @(negedge clk);
    bus.tdc_busy = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 chk("ready_edge2", 64'(bus.data_ready), 64'd0);
    @(posedge clk);
    #1 chk("ready_edge3", 64'(bus.data_ready), 64'd1);
    repeat (3) @(negedge clk);
    chk("one_count", 64'(bus.fifo_count), 64'd1);
    read_full(f);
    chk("one_frame", 64'(f), 64'(frm(1'b1, 1'b0, 1, 0, 32'h5, 9'h07A)));
    chk("one_status", 64'(f[55:48]), 64'h81);
    chk("one_count_after", 64'(bus.fifo_count), 64'd0);
    chk("one_ready_after", 64'(bus.data_ready), 64'd0);

    for (int i = 1; i <= 5; i++) capture(32'(i), 9'(16 + i));
    chk("ovf_count", 64'(bus.fifo_count), 64'd4);
    chk("ovf_flag", 64'(bus.overflow), 64'd1);
    read_full(f);
    chk("ovf_frame", 64'(f), 64'(frm(1'b1, 1'b1, 4, 1, 32'd1, 9'h011)));
    chk("ovf_status", 64'(f[55:48]), 64'hC4);
    chk("ovf_cleared", 64'(bus.overflow), 64'd0);
    chk("ovf_count_after", 64'(bus.fifo_count), 64'd3);

    spi_read(20, f);
    bus.spi_cs_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("short_bits", 64'(f[19:0]), 64'(frm(1'b1, 1'b0, 3, 2, 32'd2, 9'h012) >> 36));
    chk("short_count", 64'(bus.fifo_count), 64'd3);
    chk("short_miso", 64'(bus.spi_miso), 64'd0);
    read_full(f);
    chk("reread_frame", 64'(f), 64'(frm(1'b1, 1'b0, 3, 2, 32'd2, 9'h012)));
    chk("reread_count", 64'(bus.fifo_count), 64'd2);

    capture(32'd6, 9'h016);
    capture(32'd7, 9'h017);
    chk("fill_count", 64'(bus.fifo_count), 64'd4);
    // Busy fall and cs_n rise driven together so push and pop share one cycle.
    @(negedge clk);
    bus.tdc_busy = 1'b1;
    bus.coarse_result = 32'd8;
    bus.fine_result = 9'h018;
    spi_read(56, f);
    bus.spi_cs_n = 1'b1;
    bus.tdc_busy = 1'b0;
    repeat (6) @(negedge clk);
    chk("coll_frame", 64'(f), 64'(frm(1'b1, 1'b0, 4, 3, 32'd3, 9'h013)));
    chk("coll_count", 64'(bus.fifo_count), 64'd4);
    chk("coll_ovf", 64'(bus.overflow), 64'd0);
    read_full(f);
    chk("coll_rd4", 64'(f), 64'(frm(1'b1, 1'b0, 4, 4, 32'd4, 9'h014)));
    read_full(f);
    chk("coll_rd6", 64'(f), 64'(frm(1'b1, 1'b0, 3, 6, 32'd6, 9'h016)));
    read_full(f);
    chk("coll_rd7", 64'(f), 64'(frm(1'b1, 1'b0, 2, 7, 32'd7, 9'h017)));
    read_full(f);
    chk("coll_rd8_tail", 64'(f), 64'(frm(1'b1, 1'b0, 1, 8, 32'd8, 9'h018)));
    chk("coll_empty", 64'(bus.fifo_count), 64'd0);

    for (int i = 9; i <= 13; i++) capture(32'(i), 9'(16 + i));
    chk("seq_full_ovf", 64'(bus.overflow), 64'd1);
    read_full(f);
    chk("seq_rd9", 64'(f), 64'(frm(1'b1, 1'b1, 4, 9, 32'd9, 9'h019)));
    capture(32'd14, 9'h01E);
    read_full(f);
    chk("seq_rd10", 64'(f), 64'(frm(1'b1, 1'b0, 4, 10, 32'd10, 9'h01A)));
    read_full(f);
    chk("seq_rd11", 64'(f), 64'(frm(1'b1, 1'b0, 3, 11, 32'd11, 9'h01B)));
    read_full(f);
    chk("seq_rd12", 64'(f), 64'(frm(1'b1, 1'b0, 2, 12, 32'd12, 9'h01C)));
    read_full(f);
    chk("seq_rd14_gap", 64'(f), 64'(frm(1'b1, 1'b0, 1, 14, 32'd14, 9'h01E)));

    capture(32'hDEAD_BEEF, 9'h1FF);
    spi_read(10, f);
    chk("abort_pre_count", 64'(bus.fifo_count), 64'd1);
    rst = 1'b1;
    #1;
    chk("abort_miso", 64'(bus.spi_miso), 64'd0);
    chk("abort_count", 64'(bus.fifo_count), 64'd0);
    chk("abort_ready", 64'(bus.data_ready), 64'd0);
    bus.spi_cs_n = 1'b1;
    bus.spi_sclk = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_after_count", 64'(bus.fifo_count), 64'd0);
    chk("abort_after_miso", 64'(bus.spi_miso), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tdc_result_fifo_spi.md
Name: tdc_result_fifo_spi

Overview:
- Sits directly downstream of the TDC core.
- Detects the end of each measurement (TDC busy falling) and captures the coarse and fine results into a small FIFO.
- Serves FIFO entries to an external host over a read-only SPI slave, mode 0, MSB first.
- The SPI signals are oversampled in the system clock domain, so the block uses one clock only.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, ≥2.
- COARSE_W, 32, coarse result width.
- FINE_W, 9, fine result width.

Ports:
- clk  input  1  system clock; same clk as the TDC core.
- rst  input  1  reset; asynchronous, active-high.
- tdc_busy  input  1  TDC busy flag; asynchronous to clk.
- coarse_result  input  COARSE_W  TDC coarse result; stable while busy is low.
- fine_result  input  FINE_W  TDC fine result; stable while busy is low.
- spi_sclk  input  1  host SPI clock; asynchronous; frequency ≤ clk/8.
- spi_cs_n  input  1  host chip select, active-low; asynchronous.
- spi_miso  output  1  serial data to host.
- data_ready  output  1  FIFO non-empty.
- overflow  output  1  sticky flag: a capture was dropped.
- fifo_count  output  $clog2(DEPTH)+1  current number of entries.

Behaviour:
Clock and reset (already decided):
- One clock, clk.
- Reset rst is asynchronous and active-high.
- Reset values: FIFO empty, fifo_count=0, data_ready=0, overflow=0, spi_miso=0, all synchronisers at idle (tdc_busy=0, spi_sclk=0, spi_cs_n=1), SPI FSM in IDLE.
- Reset asserted mid-transaction aborts it: no pop, miso forced to 0.

Capture:
- tdc_busy passes through a 2-flop synchroniser plus one history flop.
- A falling edge (history=1, synced=0) generates push for one cycle, sampling {coarse_result, fine_result} on that edge.
- data_ready rises 3 clk edges after tdc_busy falls (+1 with metastability).

FIFO:
- Binary read/write pointers with wrap at DEPTH; separate count register.
- Push when full with no pop in the same cycle: record dropped, overflow set to 1.
- Push and pop in the same cycle: both performed, count unchanged. This also applies when the FIFO is full, so the push is accepted.
- Pop when empty: impossible by construction (pop requires the frame's valid bit).

SPI:
- spi_sclk and spi_cs_n each pass through a 2-flop synchroniser plus edge detect.
- FSM states: IDLE, LOAD, SHIFT, DONE.
  - IDLE → LOAD on synced cs_n fall.
  - LOAD: one cycle. Builds a 56-bit frame and drives its MSB onto miso.
  - SHIFT: on synced sclk rise, bit_cnt++. On synced sclk fall, shift left and drive the next bit.
  - SHIFT → DONE when bit_cnt reaches 56. Further sclk edges are ignored and miso holds 0.
  - SHIFT or DONE → IDLE on synced cs_n rise.
- Pop and clear:
  - On cs_n rise from DONE with valid=1: pop one entry and clear overflow, in the same cycle as any push. A push that overflows in that cycle keeps overflow set.
  - On cs_n rise from SHIFT (short read): no pop, no clear.
- Frame, MSB first:
  - Status byte: [55]=valid (FIFO non-empty at LOAD), [54]=overflow, [53:51]=0, [50:48]=fifo_count saturated at 7.
  - Record [47:0] = {7'b0, fine[8:0], coarse[31:0]}; all zero when valid=0.
- spi_miso = 0 whenever synced cs_n is high.

Optional Feature:
Macro: TDC_FIFO_SEQ_EN.
- Defined: a 7-bit capture sequence counter, reset to 0, increments on every push event, including dropped ones. Its value at capture is stored in the record's [47:41] instead of zeros, so the host can detect gaps. The counter wraps from 127 to 0.
- Undefined: [47:41] is 0 and the counter is absent.

Test Plan:
- Reset, no capture; host reads 56 bits → frame all zero, miso 0, no pop, data_ready=0.
- One capture with coarse=0x00000005, fine=0x07A; host reads 56 bits → status 0x81, record 0x00007A00000005; after cs_n rise, fifo_count=0 and data_ready=0.
- DEPTH=4, 5 captures with coarse=1..5 and no reads → fifo_count=4, overflow=1. Next read gives status 0xC4 and coarse=1; after it, overflow=0 and fifo_count=3.
- Host reads only 20 bits, then cs_n rises → no pop, fifo_count unchanged; a following full read returns the same record.
- Capture push coincides with the pop cycle of a completed read while full → fifo_count stays 4, overflow stays 0, new record lands at the tail.
- With TDC_FIFO_SEQ_EN defined, 3 captures with the 2nd dropped (FIFO pre-filled) → stored sequence numbers show a gap. Assert rst mid-SHIFT → miso=0, FIFO empty.
